// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared defaults and debug entry type for the register scoreboard
package datapath_pkg;

    localparam int RST_NREGS_DEF = 32;
    localparam int RST_TAG_W_DEF = 2;

    // Observability view of one entry at the default tag width; the RTL uses parameter-width arrays.
    typedef struct packed {
        logic                     busy;
        logic                     spec;
        logic [RST_TAG_W_DEF-1:0] tag;
    } rst_entry_t;

endpackage

// File: rtl/rst_scoreboard_if.sv
// rtl/rst_scoreboard_if.sv - dispatch/lookup/writeback/branch bundle for the register scoreboard
interface rst_scoreboard_if
    import datapath_pkg::*;
#(
    parameter int NREGS = RST_NREGS_DEF,
    parameter int TAG_W = RST_TAG_W_DEF,
    parameter int NWB   = 2,
    parameter int NRD   = 2
);
    localparam int IDX_W = $clog2(NREGS);

    logic                          di_valid;
    logic [IDX_W-1:0]              di_rd;
    logic [TAG_W-1:0]              di_tag;
    logic                          di_spec;
    logic                          di_stall;
    logic [NRD-1:0][IDX_W-1:0]     rs_idx;
    logic [NRD-1:0]                rs_busy;
    logic [NRD-1:0][TAG_W-1:0]     rs_tag;
    logic [NWB-1:0]                wb_valid;
    logic [NWB-1:0][IDX_W-1:0]     wb_rd;
    logic [NWB-1:0][TAG_W-1:0]     wb_tag;
    logic                          br_resolved;
    logic                          br_mispredict;
    logic [IDX_W:0]                busy_count;
    logic                          all_idle;

    modport master (
        output di_valid, di_rd, di_tag, di_spec, rs_idx,
               wb_valid, wb_rd, wb_tag, br_resolved, br_mispredict,
        input  di_stall, rs_busy, rs_tag, busy_count, all_idle
    );

    modport slave (
        input  di_valid, di_rd, di_tag, di_spec, rs_idx,
               wb_valid, wb_rd, wb_tag, br_resolved, br_mispredict,
        output di_stall, rs_busy, rs_tag, busy_count, all_idle
    );
endinterface

// File: rtl/rst_popcount.sv
// rtl/rst_popcount.sv - combinational population count
module rst_popcount #(
    parameter int N = 32,
    parameter int W = $clog2(N) + 1
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(bits[i]);
        end
    end
endmodule

// File: rtl/rst_scoreboard.sv
// rtl/rst_scoreboard.sv - per-register busy/tag/speculation scoreboard between dispatch and issue
module rst_scoreboard
    import datapath_pkg::*;
#(
    parameter int NREGS    = RST_NREGS_DEF,
    parameter int TAG_W    = RST_TAG_W_DEF,
    parameter int NWB      = 2,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic           CLK,
    input  logic           nRST,
    rst_scoreboard_if.slave bus
);
    localparam int IDX_W = $clog2(NREGS);

    logic [NREGS-1:0] busy, spec;
    logic [TAG_W-1:0] tag [NREGS];

    logic [NREGS-1:0] busy_n, spec_n;
    logic [TAG_W-1:0] tag_n [NREGS];
    logic [NREGS-1:0] release_now;
    logic [IDX_W:0]   count_n;
    logic             claim, squash, commit;

    // Stale writebacks (tag mismatch) never release; any matching port is enough.
    always_comb begin
        release_now = '0;
        for (int p = 0; p < NWB; p++) begin
            if (bus.wb_valid[p] && busy[bus.wb_rd[p]] && bus.wb_tag[p] == tag[bus.wb_rd[p]]) begin
                release_now[bus.wb_rd[p]] = 1'b1;
            end
        end
    end

    assign bus.di_stall = bus.di_valid & busy[bus.di_rd] & ~release_now[bus.di_rd];

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            bus.rs_busy[i] = busy[bus.rs_idx[i]] & ~release_now[bus.rs_idx[i]];
            bus.rs_tag[i]  = tag[bus.rs_idx[i]];
        end
    end

    assign claim  = bus.di_valid & ~bus.di_stall & ~((ZERO_REG != 0) && bus.di_rd == '0);
    assign squash = bus.br_resolved & bus.br_mispredict;
    assign commit = bus.br_resolved & ~bus.br_mispredict;

    // Per-entry priority: claim over squash over release; a spec claim dies with the squash.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            busy_n[r] = busy[r];
            spec_n[r] = spec[r];
            tag_n[r]  = tag[r];
            if (release_now[r]) begin
                busy_n[r] = 1'b0;
                spec_n[r] = 1'b0;
            end
            if (squash && spec[r]) begin
                busy_n[r] = 1'b0;
                spec_n[r] = 1'b0;
            end
            if (commit) begin
                spec_n[r] = 1'b0;
            end
            if (claim && bus.di_rd == IDX_W'(r) && !(squash && bus.di_spec)) begin
                busy_n[r] = 1'b1;
                spec_n[r] = bus.di_spec;
                tag_n[r]  = bus.di_tag;
            end
        end
    end

    rst_popcount #(.N(NREGS), .W(IDX_W + 1)) u_popcount (
        .bits  (busy_n),
        .count (count_n)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            busy           <= '0;
            spec           <= '0;
            for (int r = 0; r < NREGS; r++) tag[r] <= '0;
            bus.busy_count <= '0;
            bus.all_idle   <= 1'b1;
        end else begin
            busy           <= busy_n;
            spec           <= spec_n;
            for (int r = 0; r < NREGS; r++) tag[r] <= tag_n[r];
            bus.busy_count <= count_n;
            bus.all_idle   <= (count_n == '0);
        end
    end
endmodule

// File: tb/tb_rst_scoreboard.sv
// tb/tb_rst_scoreboard.sv - directed vector bench for rst_scoreboard
module tb_rst_scoreboard;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    rst_scoreboard_if #(.NREGS(32), .TAG_W(2), .NWB(2), .NRD(2)) bus ();

    rst_scoreboard #(.NREGS(32), .TAG_W(2), .NWB(2), .NRD(2), .ZERO_REG(1)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct {
        logic       dv;
        logic [4:0] drd;
        logic [1:0] dtag;
        logic       dspec;
        logic [4:0] rs0, rs1;
        logic [1:0] wbv;
        logic [4:0] wrd0;
        logic [1:0] wtag0;
        logic [4:0] wrd1;
        logic [1:0] wtag1;
        logic       br, mis;
        logic       e_stall;
        logic [1:0] e_busy;
        logic [1:0] e_tag0, e_tag1;
        logic [5:0] e_count;
        logic       e_idle;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[27];

    function automatic vec_t mk(
        input logic dv, input logic [4:0] drd, input logic [1:0] dtag, input logic dspec,
        input logic [4:0] rs0, input logic [4:0] rs1,
        input logic [1:0] wbv, input logic [4:0] wrd0, input logic [1:0] wtag0,
        input logic [4:0] wrd1, input logic [1:0] wtag1,
        input logic br, input logic mis,
        input logic e_stall, input logic [1:0] e_busy, input logic [1:0] e_tag0,
        input logic [1:0] e_tag1, input logic [5:0] e_count, input logic e_idle);
        vec_t v;
        v.dv = dv; v.drd = drd; v.dtag = dtag; v.dspec = dspec;
        v.rs0 = rs0; v.rs1 = rs1;
        v.wbv = wbv; v.wrd0 = wrd0; v.wtag0 = wtag0; v.wrd1 = wrd1; v.wtag1 = wtag1;
        v.br = br; v.mis = mis;
        v.e_stall = e_stall; v.e_busy = e_busy; v.e_tag0 = e_tag0; v.e_tag1 = e_tag1;
        v.e_count = e_count; v.e_idle = e_idle;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.di_valid      = v.dv;
        bus.di_rd         = v.drd;
        bus.di_tag        = v.dtag;
        bus.di_spec       = v.dspec;
        bus.rs_idx[0]     = v.rs0;
        bus.rs_idx[1]     = v.rs1;
        bus.wb_valid      = v.wbv;
        bus.wb_rd[0]      = v.wrd0;
        bus.wb_tag[0]     = v.wtag0;
        bus.wb_rd[1]      = v.wrd1;
        bus.wb_tag[1]     = v.wtag1;
        bus.br_resolved   = v.br;
        bus.br_mispredict = v.mis;
    endtask

    // Drive at the falling edge, check lookups mid-cycle, check registered counters after the rise.
    task automatic apply(input int idx, input vec_t v);
        @(negedge CLK);
        drive(v);
        #2;
        chk($sformatf("v%0d di_stall", idx), 32'(bus.di_stall), 32'(v.e_stall));
        chk($sformatf("v%0d rs_busy", idx),  32'(bus.rs_busy),  32'(v.e_busy));
        chk($sformatf("v%0d rs_tag0", idx),  32'(bus.rs_tag[0]), 32'(v.e_tag0));
        chk($sformatf("v%0d rs_tag1", idx),  32'(bus.rs_tag[1]), 32'(v.e_tag1));
        @(posedge CLK);
        #1;
        chk($sformatf("v%0d busy_count", idx), 32'(bus.busy_count), 32'(v.e_count));
        chk($sformatf("v%0d all_idle", idx),   32'(bus.all_idle),   32'(v.e_idle));
    endtask

    task automatic claim_cycle(input logic [4:0] rd, input logic [1:0] t);
        @(negedge CLK);
        drive(mk(1, rd, t, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //                dv rd tg sp rs0 rs1 wbv  wrd0 wt0 wrd1 wt1 br mis stl busy   t0 t1 cnt idle
        vecs[0]  = mk(1,  5, 2, 0,  5,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        vecs[1]  = mk(0,  0, 0, 0,  5,  5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2, 2, 1, 0);
        vecs[2]  = mk(0,  0, 0, 0,  5,  0, 2'b10, 0, 0, 5, 2, 0, 0, 0, 2'b00, 2, 0, 0, 1);
        vecs[3]  = mk(0,  0, 0, 0,  5,  5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2, 2, 0, 1);
        vecs[4]  = mk(1,  7, 1, 0,  7,  5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2, 1, 0);
        vecs[5]  = mk(0,  0, 0, 0,  7,  7, 2'b01, 7, 3, 0, 0, 0, 0, 0, 2'b11, 1, 1, 1, 0);
        vecs[6]  = mk(1,  9, 0, 0,  9,  7, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 1, 2, 0);
        vecs[7]  = mk(1,  9, 3, 0,  9,  9, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b11, 0, 0, 2, 0);
        vecs[8]  = mk(1,  9, 3, 0,  9,  7, 2'b01, 9, 0, 0, 0, 0, 0, 0, 2'b10, 0, 1, 2, 0);
        vecs[9]  = mk(0,  0, 0, 0,  9,  9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3, 3, 2, 0);
        vecs[10] = mk(0,  0, 0, 0,  9,  7, 2'b11, 9, 3, 7, 1, 0, 0, 0, 2'b00, 3, 1, 0, 1);
        vecs[11] = mk(1,  3, 1, 1,  3,  4, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        vecs[12] = mk(1,  4, 2, 0,  3,  4, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 2, 0);
        vecs[13] = mk(1,  6, 3, 1,  3,  4, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b11, 1, 2, 1, 0);
        vecs[14] = mk(0,  0, 0, 0,  3,  6, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0);
        vecs[15] = mk(0,  0, 0, 0,  4,  4, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2, 2, 1, 0);
        vecs[16] = mk(1,  3, 2, 1,  3,  4, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 2, 2, 0);
        vecs[17] = mk(1, 10, 1, 1,  3, 10, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2, 0, 3, 0);
        vecs[18] = mk(0,  0, 0, 0,  3, 10, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b11, 2, 1, 2, 0);
        vecs[19] = mk(0,  0, 0, 0,  3, 10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2, 1, 2, 0);
        vecs[20] = mk(1, 11, 1, 1, 11,  3, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 2, 3, 0);
        vecs[21] = mk(0,  0, 0, 0, 11,  3, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b11, 1, 2, 3, 0);
        vecs[22] = mk(0,  0, 0, 0, 11, 11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 1, 3, 0);
        vecs[23] = mk(1,  0, 3, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3, 0);
        vecs[24] = mk(0,  0, 0, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3, 0);
        vecs[25] = mk(1, 31, 2, 0, 31,  4, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b10, 0, 2, 3, 0);
        vecs[26] = mk(0,  0, 0, 0, 31, 11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2, 1, 3, 0);

        nRST = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge CLK);
        #1;
        chk("reset busy_count", 32'(bus.busy_count), 32'd0);
        chk("reset all_idle",   32'(bus.all_idle),   32'd1);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 27; i++) apply(i, vecs[i]);

        // Busy now: 3, 4, 31. Fill to ten entries, then reset during a claim.
        for (int r = 12; r < 19; r++) claim_cycle(5'(r), 2'd1);
        #1;
        chk("fill busy_count", 32'(bus.busy_count), 32'd10);
        chk("fill all_idle",   32'(bus.all_idle),   32'd0);
        @(negedge CLK);
        nRST = 1'b0;
        drive(mk(1, 20, 2, 0, 0, 0, 2'b01, 12, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        @(posedge CLK);
        #1;
        chk("mid reset busy_count", 32'(bus.busy_count), 32'd0);
        chk("mid reset all_idle",   32'(bus.all_idle),   32'd1);
        @(negedge CLK);
        nRST = 1'b1;
        drive(mk(0, 0, 0, 0, 12, 20, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("post reset rs_busy", 32'(bus.rs_busy), 32'd0);

        // Two ports on the same register: one stale, one matching -> released.
        claim_cycle(5'd2, 2'd1);
        @(negedge CLK);
        drive(mk(0, 0, 0, 0, 2, 2, 2'b11, 2, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("dual wb rs_busy", 32'(bus.rs_busy), 32'd0);
        @(posedge CLK);
        #1;
        chk("dual wb busy_count", 32'(bus.busy_count), 32'd0);
        chk("dual wb all_idle",   32'(bus.all_idle),   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
